// File: rtl/mul_fu_sched.sv
`default_nettype none
//============================================================================
// Module   : mul_fu_sched
// Purpose  : Issue scheduler for the 16x16 Wallace multiplier functional unit.
//            Arbitrates NUM_RS reservation stations, issues at most one op per
//            cycle into a LAT-stage pipeline, and broadcasts tagged 32-bit
//            products on the CDB with valid/ready backpressure and flush.
// Options  : `define MUL_SCHED_RR_EN -> round-robin arbitration
//            (undefined -> fixed priority, lowest index wins, no pointer)
// Revision : 1.0 - initial release
//============================================================================
module mul_fu_sched #(
  parameter int NUM_RS = 3,
  parameter int TAG_W  = 4,
  parameter int LAT    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_RS-1:0]       rs_req,
  input  logic [NUM_RS*TAG_W-1:0] rs_tag,
  input  logic [NUM_RS*16-1:0]    rs_a,
  input  logic [NUM_RS*16-1:0]    rs_b,
  output logic [NUM_RS-1:0]       rs_gnt,
  output logic                    cdb_valid,
  input  logic                    cdb_ready,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [31:0]             cdb_data,
  output logic                    busy
);

  // Rows remaining after each 3:2 reduction level of the 16-row tree.
  function automatic int wt_rows(input int lvl);
    int n;
    n = 16;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  localparam int WT_LVLS = 6;  // 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2

  logic                    w_adv;
  logic                    w_take;
  logic [NUM_RS-1:0]       w_pick;
  logic [TAG_W-1:0]        w_sel_tag;
  logic [15:0]             w_sel_a;
  logic [15:0]             w_sel_b;
  logic [15:0]             w_mul_a;
  logic [15:0]             w_mul_b;
  logic [31:0]             w_mul_p;
  logic [31:0]             w_out_prod;
  logic [31:0]             w_wt [WT_LVLS+1][16];
  logic [LAT-1:0]          vld_q;
  logic [TAG_W-1:0]        tag_q [LAT];

  // A stalled CDB output freezes the whole pipeline.
  assign w_adv  = !cdb_valid || cdb_ready;
  assign w_take = w_adv && !flush && rst_n;

`ifdef MUL_SCHED_RR_EN
  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] w_pick_idx;
  int               w_best;
  int               w_dist;

  // Round-robin: the requester at the smallest circular distance from ptr wins.
  always_comb begin
    w_pick     = '0;
    w_pick_idx = '0;
    w_best     = NUM_RS;
    w_dist     = 0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_dist = (i >= int'(ptr_q)) ? (i - int'(ptr_q)) : (i + NUM_RS - int'(ptr_q));
      if (rs_req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_pick     = '0;
        w_pick[i]  = 1'b1;
        w_pick_idx = PTR_W'(i);
      end
    end
  end

  assign ptr_d = (w_pick_idx == PTR_W'(NUM_RS - 1)) ? '0 : (w_pick_idx + PTR_W'(1));

  // Pointer steps past the granted station; it holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (|rs_gnt) begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest-indexed requester wins.
  always_comb begin
    w_pick = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (rs_req[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
      end
    end
  end
`endif

  assign rs_gnt = w_take ? w_pick : '0;

  // Route the granted station's tag and operands toward stage 1.
  always_comb begin
    w_sel_tag = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_gnt[i]) begin
        w_sel_tag = rs_tag[i*TAG_W +: TAG_W];
        w_sel_a   = rs_a[i*16 +: 16];
        w_sel_b   = rs_b[i*16 +: 16];
      end
    end
  end

  // 16-bit Wallace multiplier: partial products, 3:2 carry-save levels, final add.
  always_comb begin
    for (int l = 0; l <= WT_LVLS; l++) begin
      for (int r = 0; r < 16; r++) w_wt[l][r] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      w_wt[0][i] = w_mul_b[i] ? ({16'b0, w_mul_a} << i) : 32'b0;
    end
    for (int l = 1; l <= WT_LVLS; l++) begin
      for (int g = 0; g < 5; g++) begin
        if (3 * g + 2 < wt_rows(l - 1)) begin
          w_wt[l][2*g]   = w_wt[l-1][3*g] ^ w_wt[l-1][3*g+1] ^ w_wt[l-1][3*g+2];
          w_wt[l][2*g+1] = ((w_wt[l-1][3*g]   & w_wt[l-1][3*g+1]) |
                            (w_wt[l-1][3*g]   & w_wt[l-1][3*g+2]) |
                            (w_wt[l-1][3*g+1] & w_wt[l-1][3*g+2])) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < wt_rows(l - 1) % 3) begin
          w_wt[l][2*(wt_rows(l-1)/3)+r] = w_wt[l-1][3*(wt_rows(l-1)/3)+r];
        end
      end
    end
    w_mul_p = w_wt[WT_LVLS][0] + w_wt[WT_LVLS][1];
  end

  // Valid bits and tags shift on advance; flush kills every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else if (w_adv) begin
        vld_q[0] <= |rs_gnt;
        for (int s = 1; s < LAT; s++) vld_q[s] <= vld_q[s-1];
      end
      if (w_adv) begin
        tag_q[0] <= w_sel_tag;
        for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
      end
    end
  end

  if (LAT == 1) begin : g_lat1
    logic [31:0] prod_q;

    assign w_mul_a    = w_sel_a;
    assign w_mul_b    = w_sel_b;
    assign w_out_prod = prod_q;

    // Single stage: the multiplier sits in front of the only register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
      end else if (w_adv) begin
        prod_q <= w_mul_p;
      end
    end
  end else begin : g_latn
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] prod_q [LAT-1];

    assign w_mul_a    = a_q;
    assign w_mul_b    = b_q;
    assign w_out_prod = prod_q[LAT-2];

    // Stage 1 holds operands; stages 2..LAT carry the finished product.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        for (int s = 0; s < LAT - 1; s++) prod_q[s] <= '0;
      end else if (w_adv) begin
        a_q       <= w_sel_a;
        b_q       <= w_sel_b;
        prod_q[0] <= w_mul_p;
        for (int s = 1; s < LAT - 1; s++) prod_q[s] <= prod_q[s-1];
      end
    end
  end

  assign cdb_valid = vld_q[LAT-1];
  assign cdb_tag   = tag_q[LAT-1];
  assign cdb_data  = w_out_prod;
  assign busy      = |vld_q;

endmodule
`default_nettype wire
